// File: rtl/nettlp_rx_parser.sv
// nettlp_rx_parser
//   Receive-side NetTLP parser. Checks the 48-byte Eth/IPv4/UDP/NetTLP header
//   (six qwords) arriving on the 10G MAC RX AXI-Stream, extracts the NetTLP
//   seq/tstamp and the UDP port class, then passes the TLP payload straight
//   through to the PCIe side. Malformed or foreign frames are discarded whole.
//
//   Optional build macro: NETTLP_RX_STATS_EN
//     defined   -> drop_cnt / pkt_cnt are live 32-bit wrapping counters
//     undefined -> no counter registers, drop_cnt / pkt_cnt tied to zero
//
// Ports
//   clk156, eth_rst_n           : 156.25 MHz clock, async active-low reset
//   s_axis_*                    : RX stream from MAC (tuser = frame error on tlast)
//   m_axis_*                    : TLP payload stream, MAC byte order unchanged
//   hdr_valid                   : 1-cycle pulse when a header has been accepted
//   hdr_seq/hdr_tstamp/hdr_is_mr: sideband, held until the next accepted header
//   drop_cnt / pkt_cnt          : discarded / accepted frame counters

module nettlp_rx_parser #(
    parameter logic [15:0] UDP_PORT_CPL  = 16'h3000,
    parameter logic [15:0] UDP_PORT_MR   = 16'h4000,
    parameter logic        MATCH_DADDR   = 1'b0,
    parameter logic [31:0] LOCAL_IP_ADDR = 32'h0
) (
    input  logic        clk156,
    input  logic        eth_rst_n,

    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,

    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,

    output logic        hdr_valid,
    output logic [15:0] hdr_seq,
    output logic [31:0] hdr_tstamp,
    output logic        hdr_is_mr,

    output logic [31:0] drop_cnt,
    output logic [31:0] pkt_cnt
);

    typedef enum logic [1:0] {
        ST_HDR,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;

    logic [63:0] w_rev;
    logic [15:0] w_udp_dest;
    logic        w_chk_ok;
    logic        w_hdr_beat;
    logic        w_hdr_done;
    logic        w_pay_last;

    logic        r_is_mr_pend;
    logic        r_hdr_valid;
    logic [15:0] r_hdr_seq;
    logic [31:0] r_hdr_tstamp;
    logic        r_hdr_is_mr;

    // Byte-reverse the beat so the first wire byte lands in [63:56].
    always_comb begin
        w_rev = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_rev[8*i +: 8] = s_axis_tdata[8*(7-i) +: 8];
        end
    end

    assign w_udp_dest = w_rev[31:16];

    // Per-qword header check; qwords without a rule always pass.
    always_comb begin
        case (r_idx)
            3'd1:    w_chk_ok = (w_rev[31:16] == 16'h0800) &&
                                (w_rev[15:12] == 4'd4) &&
                                (w_rev[11:8]  == 4'd5);
            3'd2:    w_chk_ok = (w_rev[7:0] == 8'h11);
            3'd3:    w_chk_ok = !MATCH_DADDR ||
                                (w_rev[15:0] == LOCAL_IP_ADDR[31:16]);
            3'd4:    w_chk_ok = ((w_udp_dest == UDP_PORT_CPL) ||
                                 (w_udp_dest == UDP_PORT_MR)) &&
                                (!MATCH_DADDR ||
                                 (w_rev[63:48] == LOCAL_IP_ADDR[15:0]));
            default: w_chk_ok = 1'b1;
        endcase
    end

    assign w_hdr_beat = (r_state == ST_HDR) && s_axis_tvalid;
    assign w_hdr_done = w_hdr_beat && (r_idx == 3'd5) && w_chk_ok && !s_axis_tlast;
    assign w_pay_last = (r_state == ST_PAYLOAD) && s_axis_tvalid &&
                        m_axis_tready && s_axis_tlast;

    // State register
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            r_state <= ST_HDR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_HDR: begin
                if (s_axis_tvalid) begin
                    if (s_axis_tlast) begin
                        // Runt or failed last beat: frame is over, restart.
                        w_idx_nxt = '0;
                    end else if (!w_chk_ok) begin
                        w_state_nxt = ST_DROP;
                        w_idx_nxt   = '0;
                    end else if (r_idx == 3'd5) begin
                        w_state_nxt = ST_PAYLOAD;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_pay_last) begin
                    w_state_nxt = ST_HDR;
                    w_idx_nxt   = '0;
                end
            end
            ST_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_state_nxt = ST_HDR;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_HDR;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Output logic: payload is gated so outputs stay zero outside PAYLOAD.
    always_comb begin
        s_axis_tready = 1'b1;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        if (r_state == ST_PAYLOAD) begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tdata  = s_axis_tdata;
            m_axis_tkeep  = s_axis_tkeep;
            m_axis_tlast  = s_axis_tlast;
            m_axis_tuser  = s_axis_tuser & s_axis_tlast;
        end
    end

    // Sideband capture. The port class is seen at q4 but only published
    // together with seq/tstamp once q5 completes, so a frame rejected later
    // never disturbs the held sideband.
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            r_is_mr_pend <= 1'b0;
            r_hdr_valid  <= 1'b0;
            r_hdr_seq    <= '0;
            r_hdr_tstamp <= '0;
            r_hdr_is_mr  <= 1'b0;
        end else begin
            r_hdr_valid <= w_hdr_done;
            if (w_hdr_beat && (r_idx == 3'd4)) begin
                r_is_mr_pend <= (w_udp_dest == UDP_PORT_MR);
            end
            if (w_hdr_done) begin
                r_hdr_seq    <= w_rev[47:32];
                r_hdr_tstamp <= w_rev[31:0];
                r_hdr_is_mr  <= r_is_mr_pend;
            end
        end
    end

    assign hdr_valid  = r_hdr_valid;
    assign hdr_seq    = r_hdr_seq;
    assign hdr_tstamp = r_hdr_tstamp;
    assign hdr_is_mr  = r_hdr_is_mr;

`ifdef NETTLP_RX_STATS_EN
    logic [31:0] r_drop_cnt;
    logic [31:0] r_pkt_cnt;
    logic        w_drop_evt;

    // One drop per frame: either the failing header beat or a runt's tlast.
    assign w_drop_evt = w_hdr_beat && (!w_chk_ok || s_axis_tlast);

    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            r_drop_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            if (w_drop_evt) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
            if (w_pay_last) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign pkt_cnt  = r_pkt_cnt;
`else
    assign drop_cnt = '0;
    assign pkt_cnt  = '0;
`endif

endmodule

// File: tb/tb_nettlp_rx_parser.sv
// tb_nettlp_rx_parser
//   Randomized bench for nettlp_rx_parser. Frames are built as byte arrays in
//   wire order; a byte-offset reference model decides accept/drop and the
//   expected sideband, payload beats and frame counters.

module tb_nettlp_rx_parser;

    localparam logic [15:0] P_CPL = 16'h3000;
    localparam logic [15:0] P_MR  = 16'h4000;

    logic        clk156 = 1'b0;
    logic        eth_rst_n;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        hdr_valid;
    logic [15:0] hdr_seq;
    logic [31:0] hdr_tstamp;
    logic        hdr_is_mr;
    logic [31:0] drop_cnt;
    logic [31:0] pkt_cnt;

    always #5 clk156 = ~clk156;

    nettlp_rx_parser #(
        .UDP_PORT_CPL (P_CPL),
        .UDP_PORT_MR  (P_MR),
        .MATCH_DADDR  (1'b0),
        .LOCAL_IP_ADDR(32'h0)
    ) dut (
        .clk156       (clk156),
        .eth_rst_n    (eth_rst_n),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .hdr_valid    (hdr_valid),
        .hdr_seq      (hdr_seq),
        .hdr_tstamp   (hdr_tstamp),
        .hdr_is_mr    (hdr_is_mr),
        .drop_cnt     (drop_cnt),
        .pkt_cnt      (pkt_cnt)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- downstream ready generator ----------------
    int unsigned rdy_mode = 0;   // 0: always 1, 1: toggle, 2: random
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk156);
            #1;
            case (rdy_mode)
                1:       m_axis_tready = ~m_axis_tready;
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    // ---------------- output monitor ----------------
    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    beat_t       out_q[$];
    logic [48:0] hdr_q[$];
    int unsigned tvalid_cyc = 0;
    int unsigned hv_cyc = 0;

    always @(negedge clk156) begin
        if (eth_rst_n) begin
            if (m_axis_tvalid) tvalid_cyc++;
            if (m_axis_tvalid && m_axis_tready)
                out_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
            if (hdr_valid) begin
                hv_cyc++;
                hdr_q.push_back({hdr_seq, hdr_tstamp, hdr_is_mr});
            end
        end
    end

    // ---------------- frame construction ----------------
    logic [63:0] fr[$];
    logic [7:0]  fr_keep;
    logic        fr_user;

    task automatic make_frame(input logic [15:0] etype, input logic [7:0] verihl,
                              input logic [7:0] proto, input logic [15:0] dest,
                              input logic [15:0] seq, input logic [31:0] ts,
                              input int unsigned nbeats, input logic [7:0] lkeep,
                              input logic user);
        logic [7:0]  b[48];
        logic [63:0] q;
        for (int i = 0; i < 48; i++) b[i] = 8'($urandom);
        b[12] = etype[15:8];  b[13] = etype[7:0];
        b[14] = verihl;
        b[23] = proto;
        b[36] = dest[15:8];   b[37] = dest[7:0];
        b[42] = seq[15:8];    b[43] = seq[7:0];
        b[44] = ts[31:24];    b[45] = ts[23:16];
        b[46] = ts[15:8];     b[47] = ts[7:0];
        fr.delete();
        for (int w = 0; w < int'(nbeats); w++) begin
            if (w < 6) begin
                for (int j = 0; j < 8; j++) q[8*j +: 8] = b[8*w + j];
            end else begin
                q = {$urandom, $urandom};
            end
            fr.push_back(q);
        end
        fr_keep = lkeep;
        fr_user = user;
    endtask

    function automatic logic [7:0] fbyte(input int unsigned k);
        logic [63:0] w;
        w = fr[k / 8];
        return w[8*(k % 8) +: 8];
    endfunction

    // ---------------- driver ----------------
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic u, input logic mirror);
        logic done = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk156);
            if (mirror) check("tready_mirror", s_axis_tready, m_axis_tready);
            if (s_axis_tready) done = 1'b1;
            @(posedge clk156);
            #1;
        end
        check("beat_timeout", done, 1'b1);
        s_axis_tvalid = 1'b0;
    endtask

    // ---------------- reference model state ----------------
    int unsigned exp_drop = 0;
    int unsigned exp_pkt  = 0;
    logic [15:0] last_seq = '0;
    logic [31:0] last_ts  = '0;
    logic        last_mr  = 1'b0;

    task automatic run_and_check();
        int unsigned nb;
        logic        acc;
        logic [15:0] dest;
        beat_t       eb;
        nb  = fr.size();
        acc = 1'b0;
        dest = '0;
        if (nb > 6) begin
            dest = {fbyte(36), fbyte(37)};
            acc  = ({fbyte(12), fbyte(13)} == 16'h0800) &&
                   (fbyte(14)[7:4] == 4'd4) && (fbyte(14)[3:0] == 4'd5) &&
                   (fbyte(23) == 8'h11) &&
                   ((dest == P_CPL) || (dest == P_MR));
        end

        out_q.delete();
        hdr_q.delete();
        tvalid_cyc = 0;
        hv_cyc = 0;

        for (int unsigned i = 0; i < nb; i++) begin
            logic last;
            last = (i == nb - 1);
            send_beat(fr[i], last ? fr_keep : 8'hFF, last,
                      last ? fr_user : 1'($urandom_range(0, 1)), acc && (i >= 6));
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk156);
                #1;
            end
        end
        repeat (3) @(posedge clk156);
        #1;

        if (acc) begin
            exp_pkt++;
            last_seq = {fbyte(42), fbyte(43)};
            last_ts  = {fbyte(44), fbyte(45), fbyte(46), fbyte(47)};
            last_mr  = (dest == P_MR);
            check("hdr_valid_pulses", hv_cyc, 1);
            if (hdr_q.size() != 0)
                check("hdr_pulse_fields", hdr_q[0], {last_seq, last_ts, last_mr});
            check("payload_beats", out_q.size(), nb - 6);
            for (int unsigned i = 6; i < nb && (i - 6) < out_q.size(); i++) begin
                eb.d = fr[i];
                eb.k = (i == nb - 1) ? fr_keep : 8'hFF;
                eb.l = (i == nb - 1);
                eb.u = (i == nb - 1) ? fr_user : 1'b0;
                check("pay_tdata", out_q[i-6].d, eb.d);
                check("pay_tkeep", out_q[i-6].k, eb.k);
                check("pay_tlast", out_q[i-6].l, eb.l);
                check("pay_tuser", out_q[i-6].u, eb.u);
            end
        end else begin
            exp_drop++;
            check("drop_no_tvalid", tvalid_cyc, 0);
            check("drop_no_hdr_valid", hv_cyc, 0);
        end
        check("hdr_seq", hdr_seq, last_seq);
        check("hdr_tstamp", hdr_tstamp, last_ts);
        check("hdr_is_mr", hdr_is_mr, last_mr);
`ifdef NETTLP_RX_STATS_EN
        check("drop_cnt", drop_cnt, exp_drop);
        check("pkt_cnt", pkt_cnt, exp_pkt);
`else
        check("drop_cnt_tied", drop_cnt, 0);
        check("pkt_cnt_tied", pkt_cnt, 0);
`endif
    endtask

    task automatic check_reset_outputs();
        check("rst_s_tready", s_axis_tready, 1'b1);
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_m_tdata", m_axis_tdata, 64'h0);
        check("rst_m_tkeep", m_axis_tkeep, 8'h0);
        check("rst_m_tlast", m_axis_tlast, 1'b0);
        check("rst_m_tuser", m_axis_tuser, 1'b0);
        check("rst_hdr_valid", hdr_valid, 1'b0);
        check("rst_hdr_seq", hdr_seq, 16'h0);
        check("rst_hdr_tstamp", hdr_tstamp, 32'h0);
        check("rst_hdr_is_mr", hdr_is_mr, 1'b0);
        check("rst_drop_cnt", drop_cnt, 32'h0);
        check("rst_pkt_cnt", pkt_cnt, 32'h0);
    endtask

    task automatic model_reset();
        exp_drop = 0;
        exp_pkt  = 0;
        last_seq = '0;
        last_ts  = '0;
        last_mr  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        eth_rst_n     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        #22;
        check_reset_outputs();
        @(negedge clk156);
        eth_rst_n = 1'b1;
        @(posedge clk156);
        #1;

        // Valid MR frame, 3 payload beats, ready always high
        rdy_mode = 0;
        make_frame(16'h0800, 8'h45, 8'h11, P_MR, 16'h0012, 32'hDEADBEEF, 9, 8'hFF, 1'b0);
        run_and_check();

        // Valid CPL frame with toggling ready
        rdy_mode = 1;
        make_frame(16'h0800, 8'h45, 8'h11, P_CPL, 16'h0345, 32'h01234567, 11, 8'hFF, 1'b0);
        run_and_check();
        rdy_mode = 0;

        // IPv6 EtherType, 10 beats, then a normal frame
        make_frame(16'h86DD, 8'h45, 8'h11, P_MR, 16'h1111, 32'h22222222, 10, 8'hFF, 1'b0);
        run_and_check();
        make_frame(16'h0800, 8'h45, 8'h11, P_MR, 16'h0777, 32'h0BADF00D, 8, 8'hFF, 1'b0);
        run_and_check();

        // Foreign UDP port, then a runt ending on q3, then a normal frame
        make_frame(16'h0800, 8'h45, 8'h11, 16'h5000, 16'h3333, 32'h44444444, 9, 8'hFF, 1'b0);
        run_and_check();
        make_frame(16'h0800, 8'h45, 8'h11, P_MR, 16'h5555, 32'h66666666, 4, 8'hFF, 1'b0);
        run_and_check();
        make_frame(16'h0800, 8'h45, 8'h11, P_CPL, 16'h0888, 32'hCAFEF00D, 7, 8'hFF, 1'b0);
        run_and_check();

        // Frame error and partial keep on the last payload beat
        make_frame(16'h0800, 8'h45, 8'h11, P_MR, 16'h0999, 32'h13579BDF, 10, 8'h0F, 1'b1);
        run_and_check();

        // Randomized mix of good, corrupt and runt frames
        for (int n = 0; n < 40; n++) begin
            int unsigned kind;
            logic [15:0] et, dst;
            logic [7:0]  vi, pr;
            int unsigned nb;
            kind = $urandom_range(0, 6);
            rdy_mode = $urandom_range(0, 2);
            et  = (kind == 2) ? {8'h88, 8'($urandom)} : 16'h0800;
            vi  = (kind == 3) ? (n[0] ? 8'h46 : 8'h65) : 8'h45;
            pr  = (kind == 4) ? 8'h06 : 8'h11;
            dst = (kind == 5) ? (16'h5000 + 16'($urandom_range(0, 255))) :
                  (kind == 1) ? P_CPL : P_MR;
            nb  = (kind == 6) ? $urandom_range(1, 6) : 6 + $urandom_range(1, 4);
            make_frame(et, vi, pr, dst, 16'($urandom), $urandom, nb,
                       8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)));
            run_and_check();
        end
        rdy_mode = 0;
        repeat (2) @(posedge clk156);
        #1;

        // Reset asserted while a payload beat is being presented
        make_frame(16'h0800, 8'h45, 8'h11, P_MR, 16'hABCD, 32'h89ABCDEF, 10, 8'hFF, 1'b0);
        for (int i = 0; i < 7; i++) send_beat(fr[i], 8'hFF, 1'b0, 1'b0, i >= 6);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = fr[7];
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        @(negedge clk156);
        check("pre_rst_payload_tvalid", m_axis_tvalid, 1'b1);
        #1;
        eth_rst_n = 1'b0;
        #1;
        check_reset_outputs();
        s_axis_tvalid = 1'b0;
        @(posedge clk156);
        @(negedge clk156);
        eth_rst_n = 1'b1;
        model_reset();
        @(posedge clk156);
        #1;
        make_frame(16'h0800, 8'h45, 8'h11, P_CPL, 16'h2468, 32'h0F0F0F0F, 9, 8'h3F, 1'b0);
        run_and_check();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
